nios_system_sysid_checker: RTL and testbench
============================================

# nios_system_sysid_checker

Avalon-MM read master (initiator) that reads the system-ID slave's two words, ID at address 0 and timestamp at address 1, and compares them against build-time expected values. It sits beside the Nios system interconnect on the same clock. It raises pass/fail/timeout flags so board logic can gate the visualizer datapath when a stale or mismatched bitstream/software pair is loaded. It runs automatically after reset and again on each `start` pulse.

## Interface
- `EXPECTED_ID`, default 32'd0: value required at address 0.
- `EXPECTED_TIMESTAMP`, default 32'd1433223846: value required at address 1.
- `TIMEOUT_CYCLES`, default 255: maximum cycles per read transaction (waitrequest plus response wait); range 1..65535.
- `MAX_RETRIES`, default 3: re-issues per word after a timeout; range 0..15.
- `AUTO_START`, default 1: 1 starts a check on the first cycle after reset deasserts.

Ports:
- `clock` in 1: single clock. Synchronous active-high reset.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to run a check. Ignored while `busy`.
- `avm_address` out 1: 0 = ID, 1 = timestamp.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave stall. The request is held while this is high.
- `avm_readdata` in 32: response data.
- `avm_readdatavalid` in 1: response strobe.
- `busy` out 1: check in progress.
- `done` out 1: one-cycle pulse when a check completes (pass, fail or timeout).
- `id_ok` out 1: last ID read matched.
- `ts_ok` out 1: last timestamp read matched.
- `timed_out` out 1: last check abandoned after retries were exhausted.
- `id_value` out 32: last captured ID word.
- `ts_value` out 32: last captured timestamp word.

## Operation
- FSM states: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, FINISH.
- IDLE:
  - `start` → REQ_ID.
  - First cycle after reset with AUTO_START=1 → REQ_ID.
  - On entry to REQ_ID, clear `id_ok`, `ts_ok` and `timed_out`, and clear the retry counter.
- REQ_x:
  - Drive `avm_read`=1 and `avm_address`=x.
  - Stay in REQ_x while `avm_waitrequest`=1.
  - Go to WAIT_x on the cycle where `avm_read`=1 and `avm_waitrequest`=0 (request accepted).
  - If `avm_readdatavalid` is also high in that cycle (zero-latency slave), capture the data and skip WAIT_x.
- WAIT_x:
  - `avm_read`=0.
  - On `avm_readdatavalid`, capture `avm_readdata` into the x_value register and set x_ok = (data == EXPECTED_x).
  - ID → REQ_TS, clear the retry counter.
  - TS → FINISH.
- Compare failure does not retry. It only clears the x_ok flag, and the check continues to the timestamp read regardless.
- Timeout counter:
  - Reset to 0 on entry to each REQ_x.
  - Increments every cycle in REQ_x and WAIT_x.
  - Reaching TIMEOUT_CYCLES:
    - If retries < MAX_RETRIES: increment retries and return to REQ_x. This is allowed even while the slave is stalling.
    - Otherwise: set `timed_out`=1 and go to FINISH. x_ok stays 0, and later words are not read.
- Late response: `avm_readdatavalid` arriving in REQ_x after a timeout-retry is captured as that word's response, and the FSM advances as if the wait completed.
- Stray response: `avm_readdatavalid` in IDLE or FINISH is ignored.
- FINISH: pulse `done` for 1 cycle, then go to IDLE.
- `busy` = (state ≠ IDLE).
- Flags and value registers hold until the next check starts.
- Reset mid-operation: returns to IDLE immediately. The next cycle's outputs are all at reset values, and no bus request is left asserted.

## Timing
- Reset values: state IDLE. The following outputs are 0: `avm_read`, `avm_address`, `busy`, `done`, `id_ok`, `ts_ok`, `timed_out`, `id_value`, `ts_value`.
- `avm_read` and `avm_address` are registered, so they are glitch-free and change only on clock edges.
- Latency with a zero-wait, 1-cycle-readdatavalid slave: `start` at cycle 0 gives:
  - REQ_ID at cycle 1
  - WAIT_ID at cycle 2
  - REQ_TS at cycle 3
  - WAIT_TS at cycle 4
  - FINISH/`done` at cycle 5
- Flags are valid in the same cycle as `done` and remain stable afterwards.
- `start` in the same cycle as `reset` is ignored.
- Worst-case check length: 2 × (MAX_RETRIES+1) × TIMEOUT_CYCLES + 3 cycles.

## Structure
- A shared package `nios_sysid_pkg` holds:
  - the state encoding type
  - the address constants `SYSID_ADDR_ID`=0 and `SYSID_ADDR_TS`=1
  - the default expected values
- One natural sub-module: `sysid_timeout_ctr`, a loadable down-counter with an expiry strobe, reused for both reads.

## Test plan
- Default sysid model (ID 0, TS 1433223846), zero wait, 1-cycle latency, AUTO_START=1 → `done` pulses 5 cycles after reset release; `id_ok`=1, `ts_ok`=1, `timed_out`=0, `ts_value`=1433223846.
- Model returns TS 1433223845 → `ts_ok`=0, `id_ok`=1, `done` pulses, `timed_out`=0.
- `avm_waitrequest` held high for 3 cycles on each read → `avm_read` is held and the address stays stable; completes with both flags =1 at cycle 11.
- Slave never asserts `avm_readdatavalid`, with TIMEOUT_CYCLES=8 and MAX_RETRIES=2 → 3 ID requests issued, then `timed_out`=1 and `done` pulses. No TS request is issued.
- Reset asserted in WAIT_TS → next cycle `avm_read`=0, `busy`=0, and all flags are 0. With AUTO_START=1, a fresh check starts after release.
- `start` pulsed while `busy` → ignored, and exactly one `done` pulse occurs. `start` after completion reruns the check and clears the flags on entry to REQ_ID.

Source files
------------

// File: rtl/nios_system_sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM encoding,
// sysid slave word addresses and the default build-time expected values.
package nios_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_ID  = 3'd1,
        WAIT_ID = 3'd2,
        REQ_TS  = 3'd3,
        WAIT_TS = 3'd4,
        FINISH  = 3'd5
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1433223846;

    // Counter widths cover TIMEOUT_CYCLES up to 65535 and MAX_RETRIES up to 15.
    localparam int SYSID_CTR_WIDTH   = 16;
    localparam int SYSID_RETRY_WIDTH = 4;

    function automatic logic is_req_state(input sysid_state_e s);
        return (s == REQ_ID) || (s == REQ_TS);
    endfunction

endpackage

// File: rtl/nios_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the
// system-ID slave.
interface nios_system_sysid_checker_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/nios_system_sysid_checker_timeout_ctr.sv
// Loadable down-counter bounding one read transaction; o_expired is high
// while counting and the remaining budget has reached zero.
module sysid_timeout_ctr
    import nios_sysid_pkg::*;
#(
    parameter int WIDTH = SYSID_CTR_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_en,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = i_en && (r_count == '0);

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Reads the sysid ID and timestamp words after reset or on start, compares
// them to build-time values and reports pass/fail/timeout to board logic.
module nios_system_sysid_checker
    import nios_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3,
    parameter int          AUTO_START         = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    nios_system_sysid_checker_if.master   avm,
    output logic                          busy,
    output logic                          done,
    output logic                          id_ok,
    output logic                          ts_ok,
    output logic                          timed_out,
    output logic [31:0]                   id_value,
    output logic [31:0]                   ts_value
);

    // The counter is loaded with budget-1 so expiry lands on the
    // TIMEOUT_CYCLES-th cycle of an attempt.
    localparam logic [SYSID_CTR_WIDTH-1:0] LP_TIMEOUT_LOAD =
        SYSID_CTR_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [SYSID_RETRY_WIDTH-1:0] LP_MAX_RETRIES =
        SYSID_RETRY_WIDTH'(MAX_RETRIES);

    sysid_state_e                 r_state;
    sysid_state_e                 w_state_next;
    logic [SYSID_RETRY_WIDTH-1:0] r_retries;
    logic                         r_auto_pending;
    logic                         r_read;
    logic                         r_addr;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_id_ok;
    logic                         r_ts_ok;
    logic                         r_timed_out;
    logic [31:0]                  r_id_value;
    logic [31:0]                  r_ts_value;

    logic w_expired;
    logic w_ctr_load;
    logic w_ctr_en;
    logic w_retry_avail;
    logic w_retry;
    logic w_cap_id;
    logic w_cap_ts;
    logic w_set_to;
    logic w_clear;
    logic w_clr_retries;

    assign w_retry_avail = (r_retries < LP_MAX_RETRIES);
    assign w_ctr_en      = (r_state != IDLE) && (r_state != FINISH);
    assign w_ctr_load    = w_retry ||
                           (is_req_state(w_state_next) && (w_state_next != r_state));

    sysid_timeout_ctr #(
        .WIDTH (SYSID_CTR_WIDTH)
    ) u_timeout_ctr (
        .clock        (clock),
        .reset        (reset),
        .i_load       (w_ctr_load),
        .i_load_value (LP_TIMEOUT_LOAD),
        .i_en         (w_ctr_en),
        .o_expired    (w_expired)
    );

    // A response always wins over an expiry in the same cycle; a response
    // seen in REQ_x (zero-latency or late after a retry) completes the word.
    always_comb begin
        w_state_next  = r_state;
        w_retry       = 1'b0;
        w_cap_id      = 1'b0;
        w_cap_ts      = 1'b0;
        w_set_to      = 1'b0;
        w_clear       = 1'b0;
        w_clr_retries = 1'b0;
        case (r_state)
            IDLE: begin
                if (start || r_auto_pending) begin
                    w_state_next = REQ_ID;
                    w_clear      = 1'b1;
                end
            end
            REQ_ID, WAIT_ID: begin
                if (avm.avm_readdatavalid) begin
                    w_cap_id      = 1'b1;
                    w_clr_retries = 1'b1;
                    w_state_next  = REQ_TS;
                end else if (w_expired) begin
                    if (w_retry_avail) begin
                        w_retry      = 1'b1;
                        w_state_next = REQ_ID;
                    end else begin
                        w_set_to     = 1'b1;
                        w_state_next = FINISH;
                    end
                end else if ((r_state == REQ_ID) && !avm.avm_waitrequest) begin
                    w_state_next = WAIT_ID;
                end
            end
            REQ_TS, WAIT_TS: begin
                if (avm.avm_readdatavalid) begin
                    w_cap_ts     = 1'b1;
                    w_state_next = FINISH;
                end else if (w_expired) begin
                    if (w_retry_avail) begin
                        w_retry      = 1'b1;
                        w_state_next = REQ_TS;
                    end else begin
                        w_set_to     = 1'b1;
                        w_state_next = FINISH;
                    end
                end else if ((r_state == REQ_TS) && !avm.avm_waitrequest) begin
                    w_state_next = WAIT_TS;
                end
            end
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Bus and status outputs are decoded from the next state so they are
    // registered and line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_auto_pending <= (AUTO_START != 0);
            r_retries      <= '0;
            r_read         <= 1'b0;
            r_addr         <= SYSID_ADDR_ID;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_id_ok        <= 1'b0;
            r_ts_ok        <= 1'b0;
            r_timed_out    <= 1'b0;
            r_id_value     <= '0;
            r_ts_value     <= '0;
        end else begin
            r_state        <= w_state_next;
            r_auto_pending <= 1'b0;
            r_read         <= is_req_state(w_state_next);
            r_addr         <= (w_state_next == REQ_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
            r_busy         <= (w_state_next != IDLE);
            r_done         <= (w_state_next == FINISH);

            if (w_clear) begin
                r_id_ok     <= 1'b0;
                r_ts_ok     <= 1'b0;
                r_timed_out <= 1'b0;
            end
            if (w_cap_id) begin
                r_id_value <= avm.avm_readdata;
                r_id_ok    <= (avm.avm_readdata == EXPECTED_ID);
            end
            if (w_cap_ts) begin
                r_ts_value <= avm.avm_readdata;
                r_ts_ok    <= (avm.avm_readdata == EXPECTED_TIMESTAMP);
            end
            if (w_set_to) begin
                r_timed_out <= 1'b1;
            end

            if (w_clear || w_clr_retries) begin
                r_retries <= '0;
            end else if (w_retry) begin
                r_retries <= r_retries + 1'b1;
            end
        end
    end

    assign avm.avm_read    = r_read;
    assign avm.avm_address = r_addr;
    assign busy            = r_busy;
    assign done            = r_done;
    assign id_ok           = r_id_ok;
    assign ts_ok           = r_ts_ok;
    assign timed_out       = r_timed_out;
    assign id_value        = r_id_value;
    assign ts_value        = r_ts_value;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Bench for nios_system_sysid_checker: behavioural sysid slave, table of
// check scenarios and a scoreboard popped on every done pulse.
module tb_nios_system_sysid_checker;

    localparam int          T       = 8;
    localparam int          R       = 2;
    localparam logic [31:0] TS_GOOD = 32'd1433223846;
    localparam logic [31:0] TS_BAD  = 32'd1433223845;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, id_ok, ts_ok, timed_out;
    logic [31:0] id_value, ts_value;

    nios_system_sysid_checker_if bus ();

    nios_system_sysid_checker #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (TS_GOOD),
        .TIMEOUT_CYCLES     (T),
        .MAX_RETRIES        (R),
        .AUTO_START         (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .avm       (bus),
        .busy      (busy),
        .done      (done),
        .id_ok     (id_ok),
        .ts_ok     (ts_ok),
        .timed_out (timed_out),
        .id_value  (id_value),
        .ts_value  (ts_value)
    );

    always #5 clock = ~clock;

    // mode: 0 = data in the accept cycle, 1 = one cycle later, 2 = never
    typedef struct {
        int          wait_n;
        int          mode;
        logic [31:0] id_d;
        logic [31:0] ts_d;
        int          cyc;
        bit          id_ok;
        bit          ts_ok;
        bit          to;
        int          id_acc;
        int          ts_acc;
        bit          cap_id;
        bit          cap_ts;
    } vec_t;

    typedef struct {
        int          start_cyc;
        int          cyc;
        bit          id_ok;
        bit          ts_ok;
        bit          to;
        int          id_acc;
        int          ts_acc;
        logic [31:0] id_val;
        logic [31:0] ts_val;
    } exp_t;

    vec_t vecs [8];
    exp_t q [$];

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          s_wait   = 0;
    int          s_mode   = 1;
    logic [31:0] s_id     = 32'd0;
    logic [31:0] s_ts     = TS_GOOD;
    int          id_acc   = 0;
    int          ts_acc   = 0;
    logic [31:0] m_id     = 32'd0;
    logic [31:0] m_ts     = 32'd0;

    bit          pend         = 1'b0;
    logic [31:0] pend_data    = 32'd0;
    int          stall        = 0;
    bit          prev_stalled = 1'b0;
    logic        prev_addr    = 1'b0;
    bit          prev_done    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %b required %b", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Slave model and done monitor share one block so acceptance counts and
    // the scoreboard see the same cycle view.
    always @(negedge clock) begin : slave_mon
        logic        v;
        logic        wr;
        logic [31:0] d;
        logic [31:0] rd;
        exp_t        e;
        if (reset) begin
            pend = 1'b0;
            stall = 0;
            prev_stalled = 1'b0;
            prev_done = 1'b0;
            bus.avm_waitrequest = 1'b0;
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata = 32'd0;
        end else begin
            v  = 1'b0;
            wr = 1'b0;
            d  = 32'hDEAD_BEEF;
            if (pend) begin
                v = 1'b1;
                d = pend_data;
                pend = 1'b0;
            end
            if (bus.avm_read === 1'b1) begin
                if (prev_stalled) chk1("stall_addr", bus.avm_address, prev_addr);
                if (stall < s_wait) begin
                    wr = 1'b1;
                    stall++;
                end else begin
                    stall = 0;
                    rd = bus.avm_address ? s_ts : s_id;
                    if (bus.avm_address) ts_acc++; else id_acc++;
                    if (s_mode == 0) begin
                        v = 1'b1;
                        d = rd;
                    end else if (s_mode == 1) begin
                        pend = 1'b1;
                        pend_data = rd;
                    end
                end
            end else begin
                stall = 0;
            end
            prev_stalled = (bus.avm_read === 1'b1) && wr;
            prev_addr = bus.avm_address;
            bus.avm_waitrequest = wr;
            bus.avm_readdatavalid = v;
            bus.avm_readdata = d;

            if (prev_done) begin
                chk1("done_width", done, 1'b0);
                chk1("idle_after_done", busy, 1'b0);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual pulse required none");
                end else begin
                    e = q.pop_front();
                    $display("check done: latency %0d id_ok %b ts_ok %b timed_out %b id 0x%08h ts 0x%08h id_reads %0d ts_reads %0d",
                             cyc - e.start_cyc, id_ok, ts_ok, timed_out, id_value, ts_value, id_acc, ts_acc);
                    chk("latency", 32'(cyc - e.start_cyc), 32'(e.cyc));
                    chk1("id_ok", id_ok, e.id_ok);
                    chk1("ts_ok", ts_ok, e.ts_ok);
                    chk1("timed_out", timed_out, e.to);
                    chk("id_reads", 32'(id_acc), 32'(e.id_acc));
                    chk("ts_reads", 32'(ts_acc), 32'(e.ts_acc));
                    chk("id_value", id_value, e.id_val);
                    chk("ts_value", ts_value, e.ts_val);
                end
            end
            prev_done = (done === 1'b1);
        end
    end

    task automatic set_slave(input vec_t v);
        s_wait = v.wait_n;
        s_mode = v.mode;
        s_id   = v.id_d;
        s_ts   = v.ts_d;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        if (v.cap_id) m_id = v.id_d;
        if (v.cap_ts) m_ts = v.ts_d;
        e.start_cyc = cyc;
        e.cyc       = v.cyc;
        e.id_ok     = v.id_ok;
        e.ts_ok     = v.ts_ok;
        e.to        = v.to;
        e.id_acc    = v.id_acc;
        e.ts_acc    = v.ts_acc;
        e.id_val    = m_id;
        e.ts_val    = m_ts;
        id_acc = 0;
        ts_acc = 0;
        q.push_back(e);
    endtask

    // Returns at the falling edge of cycle 1 of the new check.
    task automatic run_vec(input vec_t v);
        set_slave(v);
        @(negedge clock);
        push_exp(v);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int b;
        bit got;
        b = done_cnt;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clock);
            if (done_cnt != b) got = 1'b1;
        end
        chk1("done_seen", got, 1'b1);
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_read"}, bus.avm_read, 1'b0);
        chk1({tag, "_addr"}, bus.avm_address, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_id_ok"}, id_ok, 1'b0);
        chk1({tag, "_ts_ok"}, ts_ok, 1'b0);
        chk1({tag, "_timed_out"}, timed_out, 1'b0);
        chk({tag, "_id_value"}, id_value, 32'd0);
        chk({tag, "_ts_value"}, ts_value, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual no finish required finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stim
        int dc;
        //           wait  mode id          ts       cyc id ts to ida tsa cid cts
        vecs[0] = '{0,    1,   32'd0,      TS_GOOD, 5,  1, 1, 0, 1,  1,  1,  1};
        vecs[1] = '{0,    1,   32'd0,      TS_BAD,  5,  1, 0, 0, 1,  1,  1,  1};
        vecs[2] = '{3,    1,   32'd0,      TS_GOOD, 11, 1, 1, 0, 1,  1,  1,  1};
        vecs[3] = '{0,    0,   32'd0,      TS_GOOD, 3,  1, 1, 0, 1,  1,  1,  1};
        vecs[4] = '{0,    1,   32'h1234,   TS_GOOD, 5,  0, 1, 0, 1,  1,  1,  1};
        vecs[5] = '{5,    1,   32'd0,      TS_GOOD, 15, 1, 1, 0, 1,  1,  1,  1};
        vecs[6] = '{0,    2,   32'd0,      TS_GOOD, 25, 0, 0, 1, 3,  0,  0,  0};
        vecs[7] = '{1000, 1,   32'd0,      TS_GOOD, 25, 0, 0, 1, 0,  0,  0,  0};

        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk_all_zero("reset");

        // Automatic check straight out of reset.
        set_slave(vecs[0]);
        push_exp(vecs[0]);
        reset = 1'b0;
        wait_done(60);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            wait_done(100);
        end

        // Rerun after a timeout clears timed_out on entry; a start while busy is dropped.
        dc = done_cnt;
        run_vec(vecs[0]);
        chk1("rerun_to_cleared", timed_out, 1'b0);
        chk1("rerun_busy", busy, 1'b1);
        chk1("rerun_read", bus.avm_read, 1'b1);
        chk1("rerun_addr", bus.avm_address, 1'b0);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(60);
        repeat (10) @(negedge clock);
        chk("single_done", 32'(done_cnt - dc), 32'd1);

        // Rerun after a passing check clears id_ok/ts_ok on entry.
        run_vec(vecs[6]);
        chk1("rerun_id_ok_cleared", id_ok, 1'b0);
        chk1("rerun_ts_ok_cleared", ts_ok, 1'b0);
        wait_done(100);

        // Reset while waiting for the timestamp, then automatic restart.
        run_vec(vecs[0]);
        repeat (3) @(negedge clock);
        chk1("wait_ts_busy", busy, 1'b1);
        chk1("wait_ts_read", bus.avm_read, 1'b0);
        chk1("wait_ts_id_ok", id_ok, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero("midreset");
        q.delete();
        m_id = 32'd0;
        m_ts = 32'd0;
        @(negedge clock);
        push_exp(vecs[0]);
        reset = 1'b0;
        wait_done(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
